// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//
// Serialises one frame of NUM_BYTES bytes as back-to-back 8N1 UART characters
// on a single line. The most significant byte of the frame goes out first,
// and within each character the bits go out LSB first. This matches how the
// companion 3-byte command receiver assembles its frames.
//
// Handshake (valid/ready): a frame is taken on a rising clock edge where both
// frame_valid and frame_ready are high. frame_data is captured at that edge,
// and later changes on the inputs are ignored until the frame has finished.
// frame_valid while busy is simply not looked at; nothing is queued.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset (aborts any frame, line high)
//   frame_data   frame to send, MSB byte first
//   frame_valid  frame_data holds a frame to send
//   frame_ready  block is idle and will accept a frame
//   uart_tx      registered serial line, idle high
//   busy         frame in progress (~frame_ready)
//   byte_done    one-cycle pulse on the last cycle of each stop bit
//   frame_done   one-cycle pulse on the last cycle of the final stop bit
//   fsm_state    current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int NUM_BYTES    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] frame_data,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   byte_done,
    output logic                   frame_done,
    output logic [1:0]             fsm_state
);

    localparam int FW     = 8 * NUM_BYTES;
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BC_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // Pulses are registered, so they are set one cycle ahead of the last
    // stop-bit cycle in order to be visible during that last cycle.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BC_W-1:0]   BYTE_LAST = BC_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [FW-1:0]     shreg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BC_W-1:0]   byte_cnt;

    logic              bit_end;
    logic [7:0]        cur_byte;
    logic [2:0]        bit_nxt;

    // The byte currently on the line always sits in the top of the shift
    // register; it is shifted out by a whole byte when its stop bit begins.
    assign cur_byte  = shreg[FW-1 -: 8];
    assign bit_nxt   = bit_cnt + 3'd1;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign busy      = ~frame_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            uart_tx     <= 1'b1;
            frame_ready <= 1'b1;
            byte_done   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            byte_done  <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_valid) begin
                        shreg       <= frame_data;
                        state       <= START;
                        uart_tx     <= 1'b0;
                        frame_ready <= 1'b0;
                        baud_cnt    <= '0;
                        bit_cnt     <= '0;
                        byte_cnt    <= '0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_tx  <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                            shreg   <= shreg << 8;
                        end else begin
                            bit_cnt <= bit_nxt;
                            uart_tx <= cur_byte[bit_nxt];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                STOP: begin
                    if (baud_cnt == BAUD_PRE) begin
                        byte_done  <= 1'b1;
                        frame_done <= (byte_cnt == BYTE_LAST);
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_cnt == BYTE_LAST) begin
                            state       <= IDLE;
                            frame_ready <= 1'b1;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            byte_cnt <= byte_cnt + BC_W'(1);
                            state    <= START;
                            uart_tx  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Transmit counterpart of the 3-byte UART command receiver: serializes a 24-bit frame as three 8N1 UART characters on a single TX line.
- Used to echo or acknowledge PWM command frames back to the host, and to return status from the FPGA.
- Sits between the PWM control logic, which sources frames through a valid/ready handshake, and the uart_tx pad.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); minimum legal value 2.
- NUM_BYTES, 3, characters per frame; frame width is 8*NUM_BYTES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_data  in  8*NUM_BYTES  frame to send; MSB byte first on the line
- frame_valid  in  1  frame_data is valid
- frame_ready  out  1  block can accept a frame
- uart_tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress (equals ~frame_ready)
- byte_done  out  1  one-cycle pulse at the end of each character's stop bit
- frame_done  out  1  one-cycle pulse at the end of the final stop bit

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Port names are clk and rst_n.
- Reset values:
  - uart_tx=1, frame_ready=1, busy=0, byte_done=0, frame_done=0.
  - FSM is IDLE; bit counter, byte counter and baud counter are all 0.
  - Asserting rst_n low mid-frame forces uart_tx high immediately (asynchronously) and aborts the frame. The frame is not resumed.
- Handshake:
  - A frame is accepted on a rising edge where frame_valid=1 and frame_ready=1.
  - frame_data is latched into a shift register at that edge. Input changes after acceptance are ignored.
  - frame_ready drops in the cycle following acceptance.
  - frame_valid while busy has no effect; nothing is queued.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on acceptance. uart_tx=0 from the next cycle.
  - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, of the current byte. Each bit is held CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. On the last cycle of the stop bit, byte_done=1.
  - From STOP, if bytes remain -> START with no inter-character gap. Otherwise frame_done=1 in the same cycle as the last byte_done, then -> IDLE.
- Byte order: frame_data[8*NUM_BYTES-1 -: 8] is sent first and frame_data[7:0] last, mirroring how the receiver assembles bytes.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 on each bit boundary.
  - Resets to 0 on acceptance.
- Timing:
  - Frame length is exactly NUM_BYTES*10*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
  - frame_ready=1 in the cycle after frame_done.
  - If frame_valid is held high, the next frame is accepted on that first IDLE cycle. The line therefore shows exactly one extra high cycle between back-to-back frames.
- byte_done and frame_done are each high for exactly one cycle and never asserted in IDLE.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 → uart_tx=1 and frame_ready=1 held for 100 cycles; no pulses.
- Single frame 0xA5_3C_01, CLKS_PER_BIT=4 → line shows characters 0xA5, 0x3C, 0x01 in that order, each as 0,b0..b7,1 with 4-cycle bits:
  - 0xA5 decodes as bits 1,0,1,0,0,1,0,1.
  - Total frame is 120 cycles.
  - byte_done pulses at cycles 40, 80 and 120 after the first start-bit cycle.
  - frame_done coincides with the third byte_done.
- frame_valid held high for frames 0x123456 then 0xFFFFFF → second start bit begins exactly 2 cycles after frame_done (1 idle-high cycle); a UART monitor decodes 0x12 0x34 0x56 0xFF 0xFF 0xFF.
- Change frame_data and toggle frame_valid mid-frame → the transmitted frame is unchanged and frame_ready stays 0 until after frame_done.
- Assert rst_n low in the DATA state of byte 2 → uart_tx goes to 1 asynchronously before the next clock edge, busy=0, and no frame_done is issued. After release, a new frame 0x000000 transmits correctly (all data bits 0, stop bits 1).
- Timing accuracy with CLKS_PER_BIT=234 and frame 0x550000 → every bit edge of 0x55 lands at a multiple of 234 cycles from the start-bit falling edge, with zero drift across all 30 bits.
